// File: rtl/inst_prefetch_if.sv
// Bundles the prefetcher's memory-side and consumer-side signals.
// No logic here; master is the prefetcher, slave is memory + consumer.
// Flow control lives in the prefetcher (credit-gated reads, valid/ready pop).
interface inst_prefetch_if #(
    parameter int AW = 5
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir_out;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          redirect;
    logic [15:0]   redirect_pc;
    logic          halt;
    logic [3:0]    fill_cnt;

    modport master (
        output imem_en, imem_addr, ir_out, ir_pc, ir_valid, fill_cnt,
        input  imem_rdata, ir_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_en, imem_addr, ir_out, ir_pc, ir_valid, fill_cnt,
        output imem_rdata, ir_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: streams sequential words from a sync memory into a small FIFO.
// Latency: request issues combinationally, word reaches FIFO head 2 edges after the request is visible.
// Backpressure: ir_ready=0 holds the head; reads are credit-gated so the FIFO can never overflow.
module inst_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           sys_rst,
    inst_prefetch_if.master bus
);
    localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_OCC = 5'(DEPTH);
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] req_pc;
    logic          inflight;
    logic          kill;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    fill_cnt;
    logic [31:0]   word_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          ir_valid;
    logic [4:0]    occupancy;
    logic          unused_redirect_hi;

    // A slot is committed as soon as its read is issued, so the inflight read counts
    // against capacity; a same-edge pop is deliberately not credited.
    assign occupancy = {1'b0, fill_cnt} + {4'b0, inflight};
    assign issue     = sys_rst & ~bus.halt & ~bus.redirect & (occupancy < DEPTH_OCC);

    // Data returning on a redirect edge belongs to the old stream and is dropped.
    assign push      = inflight & ~kill & ~bus.redirect;
    assign ir_valid  = (fill_cnt != 4'd0);
    assign pop       = ir_valid & bus.ir_ready & ~bus.redirect;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.ir_valid  = ir_valid;
    assign bus.fill_cnt  = fill_cnt;
    assign bus.ir_out    = ir_valid ? word_mem[rd_ptr] : 32'd0;
    assign bus.ir_pc     = ir_valid ? pc_mem[rd_ptr]   : '0;

    // Only the low AW bits of the jump target address the memory.
    assign unused_redirect_hi = ^bus.redirect_pc[15:AW];

    // Fetch pointer and read tracking: one outstanding read, tagged with its address.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fetch_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            // Issue is blocked on a redirect edge, so kill only guards the edge that follows.
            kill     <= bus.redirect;
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc[AW-1:0];
            end else if (issue) begin
                fetch_pc <= fetch_pc + AW'(1);
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties it and overrides any pop.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= 4'd0;
        end else if (bus.redirect) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fill_cnt <= fill_cnt + {3'b0, push} - {3'b0, pop};
        end
    end

    // FIFO storage of {word, pc}; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

    // Credit gating must make a push into a full FIFO unreachable.
    assert property (@(posedge clk) disable iff (!sys_rst) !(push && fill_cnt == DEPTH_CNT))
        else $error("push into full prefetch FIFO");

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;
    logic clk;
    logic sys_rst;

    inst_prefetch_if #(.AW(5)) bus ();

    inst_prefetch #(.DEPTH(4), .AW(5)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus.master)
    );

    typedef struct {
        logic [31:0] word;
        logic [4:0]  pc;
    } exp_t;

    typedef struct {
        logic [15:0] tgt;
        logic [4:0]  first;
        int          n;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   checks;
    int   failures;
    int   halt_req;
    int   cyc;

    function automatic logic [31:0] word_of(input logic [4:0] pc);
        return {8'hA0, 3'b000, pc, 8'h5C, ~{3'b000, pc}};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: address sampled at the edge, data valid until the next.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= word_of(bus.imem_addr);
    end

    // Count any memory request made while halt is high.
    always @(posedge clk) begin
        if (bus.halt && bus.imem_en) halt_req <= halt_req + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic enqueue(input logic [4:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.pc   = first + 5'(k);
            e.word = word_of(e.pc);
            sb.push_back(e);
        end
    endtask

    // Pop everything the scoreboard expects; cycles counts sample points up to the last pop.
    task automatic drain(input int n, input int budget, output int cycles);
        int got;
        exp_t e;
        got    = 0;
        cycles = 0;
        bus.ir_ready = 1'b1;
        while (got < n && cycles < budget) begin
            cycles++;
            if (bus.ir_valid) begin
                e = sb.pop_front();
                check("ir_pc", 64'(bus.ir_pc), 64'(e.pc));
                check("ir_out", 64'(bus.ir_out), 64'(e.word));
                got++;
            end
            step();
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=%0d", got, n);
            sb.delete();
        end
    endtask

    task automatic do_redirect(input logic [15:0] tgt);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        step();
        bus.redirect    = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        halt_req = 0;
        vecs[0] = '{tgt: 16'h001E, first: 5'd30, n: 4};
        vecs[1] = '{tgt: 16'hFFE5, first: 5'd5,  n: 3};
        vecs[2] = '{tgt: 16'h001F, first: 5'd31, n: 2};
        vecs[3] = '{tgt: 16'h0000, first: 5'd0,  n: 3};
        vecs[4] = '{tgt: 16'h0111, first: 5'd17, n: 5};

        sys_rst         = 1'b0;
        bus.ir_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0;
        bus.halt        = 1'b0;

        // Reset state
        step();
        step();
        check("rst_fill_cnt", 64'(bus.fill_cnt), 64'd0);
        check("rst_ir_valid", 64'(bus.ir_valid), 64'd0);
        check("rst_ir_out", 64'(bus.ir_out), 64'd0);
        check("rst_ir_pc", 64'(bus.ir_pc), 64'd0);
        check("rst_imem_en", 64'(bus.imem_en), 64'd0);

        // Release: first request visible before any edge; valid after edge 2; 1/cycle.
        bus.ir_ready = 1'b1;
        sys_rst = 1'b1;
        #1;
        check("rel_imem_en", 64'(bus.imem_en), 64'd1);
        check("rel_imem_addr", 64'(bus.imem_addr), 64'd0);
        enqueue(5'd0, 4);
        drain(4, 20, cyc);
        check("rel_latency", 64'(cyc), 64'd6);

        // Stall: head held, FIFO fills to DEPTH, requests stop; then no gap on resume.
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("stall_fill_cnt", 64'(bus.fill_cnt), 64'd4);
        check("stall_imem_en", 64'(bus.imem_en), 64'd0);
        check("stall_ir_pc", 64'(bus.ir_pc), 64'd4);
        check("stall_ir_out", 64'(bus.ir_out), 64'(word_of(5'd4)));
        enqueue(5'd4, 5);
        drain(5, 20, cyc);
        check("stall_resume_cycles", 64'(cyc), 64'd5);

        // Redirect while the read of address 7 is inflight: word 7 must never appear.
        bus.ir_ready = 1'b0;
        do_redirect(16'h0005);
        cyc = 0;
        while (!(bus.imem_en && bus.imem_addr == 5'd7) && cyc < 10) begin
            step();
            cyc++;
        end
        check("kill_saw_addr7", 64'(bus.imem_en && bus.imem_addr == 5'd7), 64'd1);
        step();
        bus.ir_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0014;
        #1;
        check("kill_no_req_on_redirect", 64'(bus.imem_en), 64'd0);
        step();
        bus.redirect = 1'b0;
        check("kill_flushed_cnt", 64'(bus.fill_cnt), 64'd0);
        check("kill_flushed_valid", 64'(bus.ir_valid), 64'd0);
        step();
        check("kill_valid_edge1", 64'(bus.ir_valid), 64'd0);
        step();
        check("kill_valid_edge2", 64'(bus.ir_valid), 64'd1);
        enqueue(5'd20, 4);
        drain(4, 20, cyc);
        check("kill_stream_cycles", 64'(cyc), 64'd4);

        // Table of redirect targets: upper bits ignored, pc wraps, 2-edge restart latency.
        for (int v = 0; v < 5; v++) begin
            do_redirect(vecs[v].tgt);
            enqueue(vecs[v].first, vecs[v].n);
            drain(vecs[v].n, 40, cyc);
            check("vec_latency", 64'(cyc), 64'(vecs[v].n + 2));
        end

        // Back-to-back redirects: the last one sets the stream.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h000A;
        step();
        bus.redirect_pc = 16'h000C;
        step();
        bus.redirect = 1'b0;
        check("b2b_fill_cnt", 64'(bus.fill_cnt), 64'd0);
        enqueue(5'd12, 3);
        drain(3, 20, cyc);
        check("b2b_latency", 64'(cyc), 64'd5);

        // Halt with fill_cnt=2 and a read inflight: completes to 3, drains, no requests.
        bus.ir_ready = 1'b0;
        do_redirect(16'h0000);
        step();
        step();
        step();
        check("halt_pre_fill", 64'(bus.fill_cnt), 64'd2);
        bus.halt = 1'b1;
        #1;
        check("halt_imem_en", 64'(bus.imem_en), 64'd0);
        step();
        check("halt_inflight_done", 64'(bus.fill_cnt), 64'd3);
        enqueue(5'd0, 3);
        drain(3, 20, cyc);
        step();
        step();
        check("halt_drained_cnt", 64'(bus.fill_cnt), 64'd0);
        check("halt_drained_valid", 64'(bus.ir_valid), 64'd0);
        check("halt_no_requests", 64'(halt_req), 64'd0);
        bus.halt = 1'b0;
        enqueue(5'd3, 3);
        drain(3, 20, cyc);
        check("halt_resume_cycles", 64'(cyc), 64'd5);

        // Redirect during halt: flushes and loads pc, but no request until halt drops.
        bus.halt = 1'b1;
        do_redirect(16'h0019);
        step();
        check("halt_redir_fill", 64'(bus.fill_cnt), 64'd0);
        check("halt_redir_no_req", 64'(bus.imem_en), 64'd0);
        check("halt_redir_addr", 64'(bus.imem_addr), 64'd25);
        bus.halt = 1'b0;
        enqueue(5'd25, 2);
        drain(2, 20, cyc);

        // Asynchronous reset mid-stream with fill_cnt=3.
        bus.ir_ready = 1'b0;
        do_redirect(16'h0009);
        for (int i = 0; i < 4; i++) step();
        check("arst_pre_fill", 64'(bus.fill_cnt), 64'd3);
        sys_rst = 1'b0;
        #1;
        check("arst_ir_valid", 64'(bus.ir_valid), 64'd0);
        check("arst_fill_cnt", 64'(bus.fill_cnt), 64'd0);
        check("arst_imem_en", 64'(bus.imem_en), 64'd0);
        sys_rst = 1'b1;
        #1;
        check("arst_restart_addr", 64'(bus.imem_addr), 64'd0);
        enqueue(5'd0, 4);
        drain(4, 20, cyc);
        check("arst_restart_latency", 64'(cyc), 64'd6);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch FIFO entries (power of two, 2..8).
REQ-002 Parameter AW, default 5, SHALL set the instruction memory address width (32 words).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 sys_rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 imem_en  output  1  SHALL be the instruction memory read request.
REQ-006 imem_addr  output  AW  SHALL be the read address, valid when imem_en=1.
REQ-007 imem_rdata  input  32  SHALL be the read data, valid in the cycle after the request edge.
REQ-008 ir_out  output  32  SHALL be the instruction word at the FIFO head.
REQ-009 ir_pc  output  AW  SHALL be the address that ir_out was fetched from.
REQ-010 ir_valid  output  1  SHALL indicate that ir_out/ir_pc hold a valid instruction.
REQ-011 ir_ready  input  1  SHALL be the consumer acceptance; a pop occurs on an edge with ir_valid=1 and ir_ready=1.
REQ-012 redirect  input  1  SHALL request a flush and a restart of fetch (jump taken).
REQ-013 redirect_pc  input  16  SHALL be the jump target; only bits [AW-1:0] SHALL be used.
REQ-014 halt  input  1  SHALL block new memory requests while high.
REQ-015 fill_cnt  output  4  SHALL be the current FIFO occupancy.

Function
REQ-016 The memory SHALL be synchronous: an address sampled at edge N SHALL produce imem_rdata during cycle N..N+1, and the block SHALL write it into the FIFO at edge N+1.
REQ-017 imem_en SHALL be combinational: 1 when halt=0, redirect=0, and fill_cnt + inflight < DEPTH; imem_addr SHALL equal fetch_pc.
REQ-018 inflight SHALL be a 1-bit flag, set on an edge with imem_en=1 and cleared on the following edge unless a new request is issued at that edge.
REQ-019 On each edge with imem_en=1, fetch_pc SHALL increment by 1 modulo 2^AW (31 wraps to 0).
REQ-020 The FIFO SHALL store {word, pc} pairs and SHALL accept a push and a pop on the same edge, leaving fill_cnt unchanged.
REQ-021 Credit gating SHALL make a push to a full FIFO impossible; an attempted push with fill_cnt=DEPTH SHALL be an assertion failure.
REQ-022 ir_valid SHALL equal (fill_cnt != 0); ir_out/ir_pc SHALL be stable while ir_valid=1 and ir_ready=0.
REQ-023 Redirect at edge N SHALL, at that edge: empty the FIFO, set fetch_pc to redirect_pc[AW-1:0], mark any inflight read as killed, and ignore any pop.
REQ-024 Killed read data SHALL NOT be written into the FIFO.
REQ-025 The first request after a redirect SHALL issue in the cycle after the redirect edge; ir_valid SHALL rise 2 edges after the redirect edge.
REQ-026 halt=1 SHALL let an inflight read complete into the FIFO and SHALL retain FIFO contents; pops SHALL continue.
REQ-027 redirect while halt=1 SHALL flush the FIFO and load fetch_pc, and SHALL issue no request until halt=0.
REQ-028 Back-to-back redirects SHALL each flush; the last redirect SHALL determine fetch_pc.
REQ-029 With ir_ready held at 1 and halt=0, the block SHALL sustain one instruction per cycle.

Reset
REQ-030 While sys_rst=0, the block SHALL hold: fill_cnt=0, ir_valid=0, ir_out=0, ir_pc=0, fetch_pc=0, inflight=0, kill=0, imem_en=0.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents and any inflight read immediately (asynchronously).
REQ-032 After sys_rst rises, the first request SHALL be imem_en=1, imem_addr=0 before the first clock edge; ir_valid SHALL rise after the second edge.

Verification
REQ-033 Release reset, mem[0..3]=A0..A3, ir_ready=1 -> ir_valid rises after edge 2; ir_out A0,A1,A2,A3 with ir_pc 0,1,2,3 on consecutive cycles.
REQ-034 ir_ready=0 for 10 cycles -> fill_cnt stops at 4, imem_en=0, ir_out=A0 held; set ir_ready=1 -> A0..A3 then A4, with no gap or duplicate.
REQ-035 Redirect with redirect_pc=0x0014 while an inflight read of addr 7 exists -> word 7 is never presented; next ir_pc=20, ir_valid rises 2 edges after the redirect.
REQ-036 fetch_pc=30, ir_ready=1 -> ir_pc sequence 30,31,0,1 (wrap-around).
REQ-037 Assert halt with fill_cnt=2 and inflight=1 -> fill_cnt reaches 3, then drains to 0 with no further requests; release halt -> fetch resumes at the next sequential pc.
REQ-038 Assert sys_rst=0 mid-stream with fill_cnt=3 -> ir_valid=0 and fill_cnt=0 immediately; after release, fetch restarts at pc 0.
